reservoir_sequencer: RTL and testbench

Time-multiplexing controller for the Mackey-Glass reservoir when the nonlinearity is evaluated off-chip by the ASIC function interface. For each accepted input sample it runs VIRTUAL_NODES node updates. Each update forms the input-plus-feedback sum, launches one DAC/XADC conversion, waits for the result, and shifts the result into the virtual-node delay line. It sits between the sample source, the reservoir register chain and the asic_function_interface, and replaces the free-running node enable.

---
 rtl/reservoir_sequencer.sv | 125 ++++++++++++
 tb/tb_reservoir_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reservoir_sequencer.sv
// Time-multiplexed node-update sequencer for the Mackey-Glass reservoir: one off-chip
// conversion per virtual node, VIRTUAL_NODES updates per accepted input sample.
//
// state | meaning
// IDLE  | waiting for an input sample, in_ready high
// ISSUE | form din_reg + fb_tail, pulse asic_start
// WAIT  | hold operand, wait for asic_done or timeout
// SHIFT | pulse node_en with the captured node word
// DONE  | pulse sample_done, return to IDLE
module reservoir_sequencer #(
   parameter int VIRTUAL_NODES  = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [DATA_WIDTH-1:0] fb_tail,
   output logic                  asic_start,
   output logic [DATA_WIDTH-1:0] asic_data,
   input  logic                  asic_done,
   input  logic [15:0]           asic_result,
   output logic                  node_en,
   output logic [DATA_WIDTH-1:0] node_din,
   output logic                  sample_done,
   output logic                  busy,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   localparam int NCW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;
   localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [NCW-1:0] NODE_LAST = NCW'(VIRTUAL_NODES - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SHIFT, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_din;
   logic [DATA_WIDTH-1:0] r_asic_data;
   logic [DATA_WIDTH-1:0] r_node_din;
   logic [NCW-1:0]        r_node_cnt;
   logic [WCW-1:0]        r_wait_cnt;
   logic                  r_timeout_err;
   logic                  w_wait_last;
   logic                  w_last_node;
   logic                  w_timeout;
   logic [DATA_WIDTH-1:0] w_result_word;
   logic                  w_unused_lsb;

   assign w_wait_last   = (r_wait_cnt == WAIT_LAST);
   assign w_last_node   = (r_node_cnt == NODE_LAST);
   // A result arriving in the final WAIT cycle takes precedence over the timeout.
   assign w_timeout     = (r_state == S_WAIT) && w_wait_last && !asic_done;
   assign w_result_word = DATA_WIDTH'(asic_result[15:4]) << (DATA_WIDTH - 12);
   assign w_unused_lsb  = ^asic_result[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (asic_done || w_wait_last) w_state_nxt = S_SHIFT;
         S_SHIFT: w_state_nxt = w_last_node ? S_DONE : S_ISSUE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_din       <= '0;
         r_asic_data <= '0;
         r_node_din  <= '0;
         r_node_cnt  <= '0;
         r_wait_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_din      <= din;
                  r_node_cnt <= '0;
               end
            end
            S_ISSUE: begin
               r_asic_data <= r_din + fb_tail;
               r_wait_cnt  <= '0;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + WCW'(1);
               if (asic_done)        r_node_din <= w_result_word;
               else if (w_wait_last) r_node_din <= '0;
            end
            S_SHIFT: begin
               if (!w_last_node) r_node_cnt <= r_node_cnt + NCW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
      else if (err_clr)   r_timeout_err <= 1'b0;
   end

   assign in_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign asic_start  = (r_state == S_ISSUE);
   assign node_en     = (r_state == S_SHIFT);
   assign sample_done = (r_state == S_DONE);
   assign asic_data   = r_asic_data;
   assign node_din    = r_node_din;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Directed bench for reservoir_sequencer with VIRTUAL_NODES=4, TIMEOUT_CYCLES=8:
// per-sample vector table plus hand sequences for reset, spurious done and error clear.
module tb_reservoir_sequencer;

   localparam int VN = 4;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] din;
   logic [DW-1:0] fb_tail;
   logic          asic_start;
   logic [DW-1:0] asic_data;
   logic          asic_done;
   logic [15:0]   asic_result;
   logic          node_en;
   logic [DW-1:0] node_din;
   logic          sample_done;
   logic          busy;
   logic          timeout_err;
   logic          err_clr;

   int n_checks = 0;
   int n_errors = 0;

   reservoir_sequencer #(
      .VIRTUAL_NODES (VN),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .din        (din),
      .fb_tail    (fb_tail),
      .asic_start (asic_start),
      .asic_data  (asic_data),
      .asic_done  (asic_done),
      .asic_result(asic_result),
      .node_en    (node_en),
      .node_din   (node_din),
      .sample_done(sample_done),
      .busy       (busy),
      .timeout_err(timeout_err),
      .err_clr    (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [31:0] din;
      logic [31:0] fb;
      logic [15:0] res;
      int          k;          // WAIT cycle carrying asic_done; 0 = never
      logic [31:0] exp_data;
      logic [31:0] exp_node;
      int          exp_cycles; // acceptance+1 .. sample_done, inclusive
      bit          exp_err;
      bit          spam;       // hold in_valid while busy
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  c, start, done_cyc, n_en, k_eff;
      bit  fin;
      k_eff       = (v.k > 0) ? v.k : TO;
      din         = v.din;
      fb_tail     = v.fb;
      asic_result = v.res;
      in_valid    = 1'b1;
      tick();
      in_valid = v.spam;
      din      = ~v.din;
      c = 1; start = -1; fin = 0; n_en = 0; done_cyc = -1;
      while (!fin && c < 200) begin
         if (c == 1) begin
            check($sformatf("v%0d_start_c1", idx), {31'b0, asic_start}, 32'd1);
            check($sformatf("v%0d_ready_busy", idx), {31'b0, in_ready}, 32'd0);
         end
         if (asic_start) start = c;
         if (start >= 0 && c == start + 1)
            check($sformatf("v%0d_asic_data", idx), asic_data, v.exp_data);
         if (node_en) begin
            n_en++;
            check($sformatf("v%0d_node_din", idx), node_din, v.exp_node);
            check($sformatf("v%0d_node_en_cycle", idx), c, start + k_eff + 1);
         end
         if (sample_done) begin
            fin      = 1;
            done_cyc = c;
            in_valid = 1'b0;
         end
         asic_done = (v.k > 0 && start >= 0 && c == start + v.k);
         tick();
         c++;
      end
      asic_done = 1'b0;
      check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_cycles);
      check($sformatf("v%0d_node_en_count", idx), n_en, VN);
      check($sformatf("v%0d_idle_ready", idx), {31'b0, in_ready}, 32'd1);
      check($sformatf("v%0d_idle_busy", idx), {31'b0, busy}, 32'd0);
      check($sformatf("v%0d_timeout_err", idx), {31'b0, timeout_err}, {31'b0, v.exp_err});
   endtask

   initial begin
      vecs[0] = '{32'h0000_1000, 32'h0000_0200, 16'hABC0, 3, 32'h0000_1200, 32'hABC0_0000, 21, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFF0, 32'h0000_0020, 16'h1234, 1, 32'h0000_0010, 32'h1230_0000, 13, 1'b0, 1'b1};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 16'hFFFF, 8, 32'h8000_0000, 32'hFFF0_0000, 41, 1'b0, 1'b0};
      vecs[3] = '{32'h0000_0000, 32'h0000_0000, 16'h000F, 2, 32'h0000_0000, 32'h0000_0000, 17, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_0005, 32'h0000_0006, 16'hAAAA, 0, 32'h0000_000B, 32'h0000_0000, 41, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b1; din = 32'h1234_5678; fb_tail = 32'h0;
      asic_done = 1'b0; asic_result = 16'h0; err_clr = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_no_start", {31'b0, asic_start}, 32'd0);
      end
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_asic_data", asic_data, 32'd0);
      check("rst_node_din", node_din, 32'd0);
      check("rst_flags", {28'b0, node_en, sample_done, timeout_err, asic_start}, 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      tick();

      asic_done   = 1'b1;
      asic_result = 16'hFFF0;
      tick();
      tick();
      asic_done = 1'b0;
      check("spur_done_busy", {31'b0, busy}, 32'd0);
      check("spur_done_node_din", node_din, 32'd0);
      check("spur_done_node_en", {31'b0, node_en}, 32'd0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr", {31'b0, timeout_err}, 32'd0);

      din = 32'h0000_0100; fb_tail = 32'h0000_0001; asic_result = 16'h5550;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rw_issue", {31'b0, asic_start}, 32'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rw_ready", {31'b0, in_ready}, 32'd1);
      check("rw_busy", {31'b0, busy}, 32'd0);
      check("rw_asic_data", asic_data, 32'd0);
      rst       = 1'b0;
      asic_done = 1'b1;
      tick();
      asic_done = 1'b0;
      tick();
      check("rw_late_done_node_en", {31'b0, node_en}, 32'd0);
      check("rw_late_done_node_din", node_din, 32'd0);
      check("rw_late_done_busy", {31'b0, busy}, 32'd0);

      run_vec(vecs[0], 5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
